// File: rtl/regif_arb_pkg.sv
// regif_arb_pkg: shared types and constants for the REGIF bus arbiter.
//   arb_state_e     one-hot FSM state encoding (5 bits)
//   STAT_LOW        value a non-owner sees on CmdAck / Cmplt / Error
//   SRC_RDY_N_IDLE  value a non-owner sees on the active-low src_rdy_n
package regif_arb_pkg;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_OFFER_RD = 5'b00010,
    S_OWN_RD   = 5'b00100,
    S_OFFER_WR = 5'b01000,
    S_OWN_WR   = 5'b10000
  } arb_state_e;

  localparam logic STAT_LOW       = 1'b0;
  localparam logic SRC_RDY_N_IDLE = 1'b1;

endpackage

// File: rtl/regif_arb_mux.sv
// regif_arb_mux: combinational owner mux and status gating for the shared
// REGIF master port. No registers: a request dropped by the owning engine
// on CmdAck leaves the shared bus in the same cycle.
//   owner[0]/owner[1]   read / write engine currently owns the bus
//   rd_* / wr_*         engine-side request, address, data and gated status
//   IP2Bus_* / Bus2IP_* shared bus master port
import regif_arb_pkg::*;

module regif_arb_mux (
  input  logic [1:0]  owner,
  input  logic        rd_IP2Bus_MstRd_Req,
  input  logic [31:0] rd_IP2Bus_Mst_Addr,
  output logic        rd_Bus2IP_Mst_CmdAck,
  output logic        rd_Bus2IP_Mst_Cmplt,
  output logic        rd_Bus2IP_Mst_Error,
  output logic        rd_Bus2IP_MstRd_src_rdy_n,
  output logic [31:0] rd_Bus2IP_MstRd_d,
  input  logic        wr_IP2Bus_MstWr_Req,
  input  logic [31:0] wr_IP2Bus_Mst_Addr,
  input  logic [31:0] wr_IP2Bus_MstWr_d,
  output logic        wr_Bus2IP_Mst_CmdAck,
  output logic        wr_Bus2IP_Mst_Cmplt,
  output logic        wr_Bus2IP_Mst_Error,
  output logic        IP2Bus_MstRd_Req,
  output logic        IP2Bus_MstWr_Req,
  output logic [31:0] IP2Bus_Mst_Addr,
  output logic [31:0] IP2Bus_MstWr_d,
  input  logic        Bus2IP_Mst_CmdAck,
  input  logic        Bus2IP_Mst_Cmplt,
  input  logic        Bus2IP_Mst_Error,
  input  logic        Bus2IP_MstRd_src_rdy_n,
  input  logic [31:0] Bus2IP_MstRd_d
);

  assign IP2Bus_MstRd_Req = owner[0] & rd_IP2Bus_MstRd_Req;
  assign IP2Bus_MstWr_Req = owner[1] & wr_IP2Bus_MstWr_Req;
  assign IP2Bus_Mst_Addr  = owner[0] ? rd_IP2Bus_Mst_Addr :
                            owner[1] ? wr_IP2Bus_Mst_Addr : 32'h0;
  assign IP2Bus_MstWr_d   = owner[1] ? wr_IP2Bus_MstWr_d : 32'h0;

  assign rd_Bus2IP_Mst_CmdAck      = owner[0] ? Bus2IP_Mst_CmdAck      : STAT_LOW;
  assign rd_Bus2IP_Mst_Cmplt       = owner[0] ? Bus2IP_Mst_Cmplt       : STAT_LOW;
  assign rd_Bus2IP_Mst_Error       = owner[0] ? Bus2IP_Mst_Error       : STAT_LOW;
  assign rd_Bus2IP_MstRd_src_rdy_n = owner[0] ? Bus2IP_MstRd_src_rdy_n : SRC_RDY_N_IDLE;
  // Read data carries no qualifier of its own; src_rdy_n gating is enough.
  assign rd_Bus2IP_MstRd_d         = Bus2IP_MstRd_d;

  assign wr_Bus2IP_Mst_CmdAck = owner[1] ? Bus2IP_Mst_CmdAck : STAT_LOW;
  assign wr_Bus2IP_Mst_Cmplt  = owner[1] ? Bus2IP_Mst_Cmplt  : STAT_LOW;
  assign wr_Bus2IP_Mst_Error  = owner[1] ? Bus2IP_Mst_Error  : STAT_LOW;

endmodule

// File: rtl/regif_arb.sv
// regif_arb: round-robin owner of the single REGIF master port, shared by
// the read-access and write-access engines.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | one cycle after reset release
// OFFER_RD   | rd_my_regif offered, waiting up to OFFER_CYCLES for rd drv
// OWN_RD     | read engine owns the bus until rd_drv_regif falls
// OFFER_WR   | wr_my_regif offered, waiting up to OFFER_CYCLES for wr drv
// OWN_WR     | write engine owns the bus until wr_drv_regif falls
//
// Ports: clk, rst_n (async, active-low); per-engine my_regif grant, drv_regif
// ownership, request/address/data in and gated status out; the shared
// IP2Bus_* / Bus2IP_* port; sticky regif_timeout and regif_proto_err flags.
import regif_arb_pkg::*;

module regif_arb #(
  parameter int OFFER_CYCLES = 4,
  parameter int HOLD_TIMEOUT = 65535,
  parameter int TO_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rd_my_regif,
  input  logic        rd_drv_regif,
  input  logic        rd_IP2Bus_MstRd_Req,
  input  logic [31:0] rd_IP2Bus_Mst_Addr,
  output logic        rd_Bus2IP_Mst_CmdAck,
  output logic        rd_Bus2IP_Mst_Cmplt,
  output logic        rd_Bus2IP_Mst_Error,
  output logic        rd_Bus2IP_MstRd_src_rdy_n,
  output logic [31:0] rd_Bus2IP_MstRd_d,
  output logic        wr_my_regif,
  input  logic        wr_drv_regif,
  input  logic        wr_IP2Bus_MstWr_Req,
  input  logic [31:0] wr_IP2Bus_Mst_Addr,
  input  logic [31:0] wr_IP2Bus_MstWr_d,
  output logic        wr_Bus2IP_Mst_CmdAck,
  output logic        wr_Bus2IP_Mst_Cmplt,
  output logic        wr_Bus2IP_Mst_Error,
  output logic        IP2Bus_MstRd_Req,
  output logic        IP2Bus_MstWr_Req,
  output logic [31:0] IP2Bus_Mst_Addr,
  output logic [31:0] IP2Bus_MstWr_d,
  input  logic        Bus2IP_Mst_CmdAck,
  input  logic        Bus2IP_Mst_Cmplt,
  input  logic        Bus2IP_Mst_Error,
  input  logic        Bus2IP_MstRd_src_rdy_n,
  input  logic [31:0] Bus2IP_MstRd_d,
  output logic        regif_timeout,
  output logic        regif_proto_err
);

  localparam int OFF_W = (OFFER_CYCLES > 1) ? $clog2(OFFER_CYCLES) : 1;
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(OFFER_CYCLES - 1);
  localparam logic [TO_W-1:0]  HOLD_LIM = TO_W'(HOLD_TIMEOUT);

  arb_state_e       state;
  logic [OFF_W-1:0] off_cnt;
  logic [TO_W-1:0]  hold_cnt;
  logic [TO_W-1:0]  hold_nxt;
  logic [1:0]       owner;
  logic             rd_allowed;
  logic             wr_allowed;

  assign rd_allowed = (state == S_OFFER_RD) || (state == S_OWN_RD);
  assign wr_allowed = (state == S_OFFER_WR) || (state == S_OWN_WR);

  // Saturating so a stuck owner cannot wrap the count and re-arm the flag.
  assign hold_nxt = (hold_cnt == {TO_W{1'b1}}) ? hold_cnt : hold_cnt + 1'b1;

  // Owner comes straight from the state register, so an async reset
  // drops the shared requests immediately.
  assign owner = {state == S_OWN_WR, state == S_OWN_RD};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      rd_my_regif     <= 1'b0;
      wr_my_regif     <= 1'b0;
      off_cnt         <= '0;
      hold_cnt        <= '0;
      regif_timeout   <= 1'b0;
      regif_proto_err <= 1'b0;
    end else begin
      if ((rd_drv_regif && !rd_allowed) || (wr_drv_regif && !wr_allowed))
        regif_proto_err <= 1'b1;

      unique case (state)
        S_IDLE: begin
          state       <= S_OFFER_RD;
          rd_my_regif <= 1'b1;
          off_cnt     <= '0;
        end
        S_OFFER_RD: begin
          // Ownership takes priority over an expiring offer.
          if (rd_drv_regif) begin
            state    <= S_OWN_RD;
            hold_cnt <= '0;
            off_cnt  <= '0;
          end else if (off_cnt == OFF_LAST) begin
            state       <= S_OFFER_WR;
            off_cnt     <= '0;
            rd_my_regif <= 1'b0;
            wr_my_regif <= 1'b1;
          end else begin
            off_cnt <= off_cnt + 1'b1;
          end
        end
        S_OWN_RD: begin
          if (!rd_drv_regif) begin
            state       <= S_OFFER_WR;
            off_cnt     <= '0;
            rd_my_regif <= 1'b0;
            wr_my_regif <= 1'b1;
          end else begin
            hold_cnt <= hold_nxt;
            if (hold_nxt >= HOLD_LIM)
              regif_timeout <= 1'b1;
          end
        end
        S_OFFER_WR: begin
          if (wr_drv_regif) begin
            state    <= S_OWN_WR;
            hold_cnt <= '0;
            off_cnt  <= '0;
          end else if (off_cnt == OFF_LAST) begin
            state       <= S_OFFER_RD;
            off_cnt     <= '0;
            wr_my_regif <= 1'b0;
            rd_my_regif <= 1'b1;
          end else begin
            off_cnt <= off_cnt + 1'b1;
          end
        end
        S_OWN_WR: begin
          if (!wr_drv_regif) begin
            state       <= S_OFFER_RD;
            off_cnt     <= '0;
            wr_my_regif <= 1'b0;
            rd_my_regif <= 1'b1;
          end else begin
            hold_cnt <= hold_nxt;
            if (hold_nxt >= HOLD_LIM)
              regif_timeout <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          rd_my_regif <= 1'b0;
          wr_my_regif <= 1'b0;
        end
      endcase
    end
  end

  regif_arb_mux u_mux (
    .owner                     (owner),
    .rd_IP2Bus_MstRd_Req       (rd_IP2Bus_MstRd_Req),
    .rd_IP2Bus_Mst_Addr        (rd_IP2Bus_Mst_Addr),
    .rd_Bus2IP_Mst_CmdAck      (rd_Bus2IP_Mst_CmdAck),
    .rd_Bus2IP_Mst_Cmplt       (rd_Bus2IP_Mst_Cmplt),
    .rd_Bus2IP_Mst_Error       (rd_Bus2IP_Mst_Error),
    .rd_Bus2IP_MstRd_src_rdy_n (rd_Bus2IP_MstRd_src_rdy_n),
    .rd_Bus2IP_MstRd_d         (rd_Bus2IP_MstRd_d),
    .wr_IP2Bus_MstWr_Req       (wr_IP2Bus_MstWr_Req),
    .wr_IP2Bus_Mst_Addr        (wr_IP2Bus_Mst_Addr),
    .wr_IP2Bus_MstWr_d         (wr_IP2Bus_MstWr_d),
    .wr_Bus2IP_Mst_CmdAck      (wr_Bus2IP_Mst_CmdAck),
    .wr_Bus2IP_Mst_Cmplt       (wr_Bus2IP_Mst_Cmplt),
    .wr_Bus2IP_Mst_Error       (wr_Bus2IP_Mst_Error),
    .IP2Bus_MstRd_Req          (IP2Bus_MstRd_Req),
    .IP2Bus_MstWr_Req          (IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr           (IP2Bus_Mst_Addr),
    .IP2Bus_MstWr_d            (IP2Bus_MstWr_d),
    .Bus2IP_Mst_CmdAck         (Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt          (Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error          (Bus2IP_Mst_Error),
    .Bus2IP_MstRd_src_rdy_n    (Bus2IP_MstRd_src_rdy_n),
    .Bus2IP_MstRd_d            (Bus2IP_MstRd_d)
  );

endmodule

// File: tb/tb_regif_arb.sv
// tb_regif_arb: self-checking bench for regif_arb with default parameters.
module tb_regif_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_my_regif, rd_drv_regif, rd_IP2Bus_MstRd_Req;
  logic [31:0] rd_IP2Bus_Mst_Addr;
  logic        rd_Bus2IP_Mst_CmdAck, rd_Bus2IP_Mst_Cmplt, rd_Bus2IP_Mst_Error;
  logic        rd_Bus2IP_MstRd_src_rdy_n;
  logic [31:0] rd_Bus2IP_MstRd_d;
  logic        wr_my_regif, wr_drv_regif, wr_IP2Bus_MstWr_Req;
  logic [31:0] wr_IP2Bus_Mst_Addr, wr_IP2Bus_MstWr_d;
  logic        wr_Bus2IP_Mst_CmdAck, wr_Bus2IP_Mst_Cmplt, wr_Bus2IP_Mst_Error;
  logic        IP2Bus_MstRd_Req, IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr, IP2Bus_MstWr_d;
  logic        Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error;
  logic        Bus2IP_MstRd_src_rdy_n;
  logic [31:0] Bus2IP_MstRd_d;
  logic        regif_timeout, regif_proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regif_arb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_my_regif(rd_my_regif), .rd_drv_regif(rd_drv_regif),
    .rd_IP2Bus_MstRd_Req(rd_IP2Bus_MstRd_Req), .rd_IP2Bus_Mst_Addr(rd_IP2Bus_Mst_Addr),
    .rd_Bus2IP_Mst_CmdAck(rd_Bus2IP_Mst_CmdAck), .rd_Bus2IP_Mst_Cmplt(rd_Bus2IP_Mst_Cmplt),
    .rd_Bus2IP_Mst_Error(rd_Bus2IP_Mst_Error), .rd_Bus2IP_MstRd_src_rdy_n(rd_Bus2IP_MstRd_src_rdy_n),
    .rd_Bus2IP_MstRd_d(rd_Bus2IP_MstRd_d),
    .wr_my_regif(wr_my_regif), .wr_drv_regif(wr_drv_regif),
    .wr_IP2Bus_MstWr_Req(wr_IP2Bus_MstWr_Req), .wr_IP2Bus_Mst_Addr(wr_IP2Bus_Mst_Addr),
    .wr_IP2Bus_MstWr_d(wr_IP2Bus_MstWr_d),
    .wr_Bus2IP_Mst_CmdAck(wr_Bus2IP_Mst_CmdAck), .wr_Bus2IP_Mst_Cmplt(wr_Bus2IP_Mst_Cmplt),
    .wr_Bus2IP_Mst_Error(wr_Bus2IP_Mst_Error),
    .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr), .IP2Bus_MstWr_d(IP2Bus_MstWr_d),
    .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck), .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error(Bus2IP_Mst_Error), .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
    .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
    .regif_timeout(regif_timeout), .regif_proto_err(regif_proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_drv_regif = 0; rd_IP2Bus_MstRd_Req = 0; rd_IP2Bus_Mst_Addr = 0;
    wr_drv_regif = 0; wr_IP2Bus_MstWr_Req = 0; wr_IP2Bus_Mst_Addr = 0; wr_IP2Bus_MstWr_d = 0;
    Bus2IP_Mst_CmdAck = 0; Bus2IP_Mst_Cmplt = 0; Bus2IP_Mst_Error = 0;
    Bus2IP_MstRd_src_rdy_n = 1; Bus2IP_MstRd_d = 0;
  endtask

  // Leaves the bench just after release; the next posedge is edge 1.
  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic rand_bus();
    rd_IP2Bus_MstRd_Req = 1'($urandom); rd_IP2Bus_Mst_Addr = $urandom;
    wr_IP2Bus_MstWr_Req = 1'($urandom); wr_IP2Bus_Mst_Addr = $urandom;
    wr_IP2Bus_MstWr_d = $urandom;
    Bus2IP_Mst_CmdAck = 1'($urandom); Bus2IP_Mst_Cmplt = 1'($urandom);
    Bus2IP_Mst_Error = 1'($urandom); Bus2IP_MstRd_src_rdy_n = 1'($urandom);
    Bus2IP_MstRd_d = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #3;
    rd_IP2Bus_MstRd_Req = 1; wr_IP2Bus_MstWr_Req = 1;
    rd_IP2Bus_Mst_Addr = 32'h1234_5678; wr_IP2Bus_MstWr_d = 32'hCAFE_F00D;
    Bus2IP_Mst_CmdAck = 1; Bus2IP_Mst_Cmplt = 1; Bus2IP_Mst_Error = 1;
    Bus2IP_MstRd_src_rdy_n = 0;
    step();
    checks++;
    if ({rd_my_regif, wr_my_regif, regif_timeout, regif_proto_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {rd_my_regif, wr_my_regif, regif_timeout, regif_proto_err});
    end
    checks++;
    if ({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d} !== 66'h0) begin
      errors++;
      $display("FAIL reset_bus: got req %b%b addr %h wd %h expected all zero",
               IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d);
    end
    checks++;
    if ({rd_Bus2IP_Mst_CmdAck, rd_Bus2IP_Mst_Cmplt, rd_Bus2IP_Mst_Error, rd_Bus2IP_MstRd_src_rdy_n,
         wr_Bus2IP_Mst_CmdAck, wr_Bus2IP_Mst_Cmplt, wr_Bus2IP_Mst_Error} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_status: got %b expected 0001000",
               {rd_Bus2IP_Mst_CmdAck, rd_Bus2IP_Mst_Cmplt, rd_Bus2IP_Mst_Error, rd_Bus2IP_MstRd_src_rdy_n,
                wr_Bus2IP_Mst_CmdAck, wr_Bus2IP_Mst_Cmplt, wr_Bus2IP_Mst_Error});
    end
  endtask

  // Unclaimed offers alternate every 4 cycles starting with rd after IDLE.
  task automatic test_offer_rotation();
    logic exp_rd;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      rd_IP2Bus_MstRd_Req = 1'($urandom); wr_IP2Bus_MstWr_Req = 1'($urandom);
      step();
      exp_rd = (((k - 1) % 8) < 4);
      checks++;
      if ({rd_my_regif, wr_my_regif, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req} !== {exp_rd, !exp_rd, 2'b00}) begin
        errors++;
        $display("FAIL offer_rotation cycle %0d: got my rd/wr req rd/wr %b expected %b",
                 k, {rd_my_regif, wr_my_regif, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req}, {exp_rd, !exp_rd, 2'b00});
      end
    end
  endtask

  task automatic test_rd_own();
    do_reset();
    step();
    step();
    rd_drv_regif = 1;
    step();
    rd_IP2Bus_MstRd_Req = 1; rd_IP2Bus_Mst_Addr = 32'h0000_0040;
    #1;
    checks++;
    if ({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr} !== {2'b10, 32'h0000_0040}) begin
      errors++;
      $display("FAIL rd_own_bus: got req %b%b addr %h expected 10 00000040",
               IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr);
    end
    Bus2IP_Mst_CmdAck = 1; Bus2IP_Mst_Cmplt = 1;
    #1;
    checks++;
    if ({rd_Bus2IP_Mst_CmdAck, rd_Bus2IP_Mst_Cmplt, wr_Bus2IP_Mst_CmdAck, wr_Bus2IP_Mst_Cmplt} !== 4'b1100) begin
      errors++;
      $display("FAIL rd_own_status: got %b expected 1100",
               {rd_Bus2IP_Mst_CmdAck, rd_Bus2IP_Mst_Cmplt, wr_Bus2IP_Mst_CmdAck, wr_Bus2IP_Mst_Cmplt});
    end
    rd_IP2Bus_MstRd_Req = 0;
    #1;
    checks++;
    if (IP2Bus_MstRd_Req !== 1'b0) begin
      errors++;
      $display("FAIL rd_req_drop: got %b expected 0", IP2Bus_MstRd_Req);
    end
    step();
    Bus2IP_Mst_CmdAck = 0; Bus2IP_Mst_Cmplt = 0;
    rd_drv_regif = 0;
    rd_IP2Bus_MstRd_Req = 1;
    step();
    checks++;
    if ({rd_my_regif, wr_my_regif, IP2Bus_MstRd_Req} !== 3'b010) begin
      errors++;
      $display("FAIL rd_release: got my rd/wr req %b expected 010",
               {rd_my_regif, wr_my_regif, IP2Bus_MstRd_Req});
    end
  endtask

  task automatic test_wr_own();
    bit got = 0;
    do_reset();
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (wr_my_regif) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wr_offer_wait: got no wr offer expected one within 20 cycles");
    end
    wr_drv_regif = 1;
    step();
    wr_IP2Bus_MstWr_Req = 1; wr_IP2Bus_Mst_Addr = 32'h10; wr_IP2Bus_MstWr_d = 32'hDEAD_BEEF;
    rd_IP2Bus_MstRd_Req = 1; rd_IP2Bus_Mst_Addr = 32'h0000_0099;
    Bus2IP_Mst_Error = 1; Bus2IP_Mst_Cmplt = 1; Bus2IP_MstRd_src_rdy_n = 0;
    #1;
    checks++;
    if ({IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d} !==
        {2'b01, 32'h10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL wr_own_bus: got req %b%b addr %h wd %h expected 01 00000010 deadbeef",
               IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d);
    end
    checks++;
    if ({wr_Bus2IP_Mst_Error, wr_Bus2IP_Mst_Cmplt, rd_Bus2IP_Mst_Error, rd_Bus2IP_Mst_Cmplt,
         rd_Bus2IP_MstRd_src_rdy_n} !== 5'b11001) begin
      errors++;
      $display("FAIL wr_own_status: got %b expected 11001",
               {wr_Bus2IP_Mst_Error, wr_Bus2IP_Mst_Cmplt, rd_Bus2IP_Mst_Error, rd_Bus2IP_Mst_Cmplt,
                rd_Bus2IP_MstRd_src_rdy_n});
    end
    wr_drv_regif = 0;
    step();
    checks++;
    if ({rd_my_regif, wr_my_regif} !== 2'b10) begin
      errors++;
      $display("FAIL wr_release: got my rd/wr %b expected 10", {rd_my_regif, wr_my_regif});
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    step();
    wr_drv_regif = 1; wr_IP2Bus_MstWr_Req = 1; wr_IP2Bus_Mst_Addr = 32'h55;
    #1;
    checks++;
    if (regif_proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_err_early: got %b expected 0", regif_proto_err);
    end
    step();
    checks++;
    if ({regif_proto_err, rd_my_regif, wr_my_regif, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr} !==
        {4'b1100, 32'h0}) begin
      errors++;
      $display("FAIL proto_err: got err/my rd/my wr/wr req %b addr %h expected 1100 00000000",
               {regif_proto_err, rd_my_regif, wr_my_regif, IP2Bus_MstWr_Req}, IP2Bus_Mst_Addr);
    end
    wr_drv_regif = 0;
    step();
    checks++;
    if (regif_proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_err_sticky: got %b expected 1", regif_proto_err);
    end
  endtask

  task automatic test_both_drv();
    do_reset();
    step();
    rd_drv_regif = 1; wr_drv_regif = 1;
    rd_IP2Bus_MstRd_Req = 1; wr_IP2Bus_MstWr_Req = 1;
    step();
    checks++;
    if ({rd_my_regif, wr_my_regif, regif_proto_err, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req} !== 5'b10110) begin
      errors++;
      $display("FAIL both_drv: got my rd/wr err req rd/wr %b expected 10110",
               {rd_my_regif, wr_my_regif, regif_proto_err, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req});
    end
  endtask

  // Reference model: the bench tracks who owns the bus and derives every
  // shared/gated output from that owner and the current input values.
  task automatic test_random_traffic();
    int own;
    int target;
    bit got;
    logic [104:0] got_v, exp_v;
    logic [1:0] exp_my;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      target = $urandom_range(1, 2);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        step();
        if (target == 1 ? rd_my_regif : wr_my_regif) got = 1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL traffic_offer_wait round %0d: got no offer for engine %0d", r, target);
      end
      if (target == 1) rd_drv_regif = 1; else wr_drv_regif = 1;
      step();
      own = target;
      for (int c = 0; c < 12; c++) begin
        rand_bus();
        #1;
        exp_v = {own == 1 && rd_IP2Bus_MstRd_Req,
                 own == 2 && wr_IP2Bus_MstWr_Req,
                 own == 1 ? rd_IP2Bus_Mst_Addr : own == 2 ? wr_IP2Bus_Mst_Addr : 32'h0,
                 own == 2 ? wr_IP2Bus_MstWr_d : 32'h0,
                 own == 1 && Bus2IP_Mst_CmdAck, own == 1 && Bus2IP_Mst_Cmplt,
                 own == 1 && Bus2IP_Mst_Error, own == 1 ? Bus2IP_MstRd_src_rdy_n : 1'b1,
                 own == 2 && Bus2IP_Mst_CmdAck, own == 2 && Bus2IP_Mst_Cmplt,
                 own == 2 && Bus2IP_Mst_Error,
                 Bus2IP_MstRd_d};
        got_v = {IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d,
                 rd_Bus2IP_Mst_CmdAck, rd_Bus2IP_Mst_Cmplt, rd_Bus2IP_Mst_Error,
                 rd_Bus2IP_MstRd_src_rdy_n,
                 wr_Bus2IP_Mst_CmdAck, wr_Bus2IP_Mst_Cmplt, wr_Bus2IP_Mst_Error,
                 rd_Bus2IP_MstRd_d};
        exp_my = {own == 1, own == 2};
        checks++;
        if (got_v !== exp_v || {rd_my_regif, wr_my_regif} !== exp_my) begin
          errors++;
          $display("FAIL traffic round %0d cycle %0d owner %0d: got %h my %b expected %h my %b",
                   r, c, own, got_v, {rd_my_regif, wr_my_regif}, exp_v, exp_my);
        end
        step();
      end
      rd_drv_regif = 0; wr_drv_regif = 0;
      step();
      own = 0;
      checks++;
      if ({rd_my_regif, wr_my_regif, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req} !==
          {target == 2, target == 1, 2'b00}) begin
        errors++;
        $display("FAIL traffic_release round %0d: got %b expected %b", r,
                 {rd_my_regif, wr_my_regif, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req},
                 {target == 2, target == 1, 2'b00});
      end
    end
    checks++;
    if (regif_proto_err !== 1'b0 || regif_timeout !== 1'b0) begin
      errors++;
      $display("FAIL traffic_flags: got proto %b timeout %b expected 0 0", regif_proto_err, regif_timeout);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    rd_drv_regif = 1;
    step();
    rd_IP2Bus_MstRd_Req = 1; rd_IP2Bus_Mst_Addr = 32'hABC0;
    #1;
    checks++;
    if (IP2Bus_MstRd_Req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got req %b expected 1", IP2Bus_MstRd_Req);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({IP2Bus_MstRd_Req, rd_my_regif, wr_my_regif, IP2Bus_Mst_Addr} !== 35'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got req/my rd/my wr %b addr %h expected 000 00000000",
               {IP2Bus_MstRd_Req, rd_my_regif, wr_my_regif}, IP2Bus_Mst_Addr);
    end
    clear_inputs();
    @(posedge clk);
    #1 rst_n = 1;
    step();
    checks++;
    if ({rd_my_regif, wr_my_regif} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_restart: got my rd/wr %b expected 10", {rd_my_regif, wr_my_regif});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    rd_drv_regif = 1;
    step();
    repeat (65530) step();
    checks++;
    if (regif_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b expected 0 after 65530 hold cycles", regif_timeout);
    end
    repeat (10) step();
    checks++;
    if ({regif_timeout, rd_my_regif, wr_my_regif} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_set: got timeout/my rd/my wr %b expected 110",
               {regif_timeout, rd_my_regif, wr_my_regif});
    end
    rd_drv_regif = 0;
    step();
    checks++;
    if ({regif_timeout, rd_my_regif, wr_my_regif} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_release: got timeout/my rd/my wr %b expected 101",
               {regif_timeout, rd_my_regif, wr_my_regif});
    end
  endtask

  initial begin
    test_reset();
    test_offer_rotation();
    test_rd_own();
    test_wr_own();
    test_proto_err();
    test_both_drv();
    test_random_traffic();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2000000 time units");
    $fatal(1);
  end

endmodule

// File: doc/regif_arb.md
Name: regif_arb

Overview:
- Shares the single register-interface (REGIF) bus master port between the PCIe read-access engine (rd_acc) and the write-access engine (wr_acc).
- Offers ownership round-robin on each engine's my_regif line; the engine takes the bus by raising drv_regif and releases it by dropping drv_regif.
- While an engine owns the bus, its IP2Bus request, address and data go to the shared bus, and only that engine sees the Bus2IP status.
- Sits between the two access engines and the REGIF master attachment.

Parameters:
- OFFER_CYCLES, 4: cycles a grant offer is held before it rotates to the other engine; minimum 1.
- HOLD_TIMEOUT, 65535: owner hold cycles after which regif_timeout is set.
- TO_W, 16: width of the hold counter; must satisfy HOLD_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- rd_my_regif  out  1  grant/offer to the read engine
- rd_drv_regif  in  1  read engine owns the bus
- rd_IP2Bus_MstRd_Req  in  1  read request from the read engine
- rd_IP2Bus_Mst_Addr  in  32  read address
- rd_Bus2IP_Mst_CmdAck / rd_Bus2IP_Mst_Cmplt / rd_Bus2IP_Mst_Error  out  1 each  gated status to the read engine
- rd_Bus2IP_MstRd_src_rdy_n  out  1  gated read-data valid, active-low
- rd_Bus2IP_MstRd_d  out  32  read data, broadcast
- wr_my_regif  out  1  grant/offer to the write engine
- wr_drv_regif  in  1  write engine owns the bus
- wr_IP2Bus_MstWr_Req  in  1  write request from the write engine
- wr_IP2Bus_Mst_Addr  in  32  write address
- wr_IP2Bus_MstWr_d  in  32  write data
- wr_Bus2IP_Mst_CmdAck / wr_Bus2IP_Mst_Cmplt / wr_Bus2IP_Mst_Error  out  1 each  gated status to the write engine
- IP2Bus_MstRd_Req / IP2Bus_MstWr_Req  out  1 each  shared bus requests
- IP2Bus_Mst_Addr  out  32  shared bus address
- IP2Bus_MstWr_d  out  32  shared bus write data
- Bus2IP_Mst_CmdAck / Bus2IP_Mst_Cmplt / Bus2IP_Mst_Error / Bus2IP_MstRd_src_rdy_n  in  1 each  shared bus status
- Bus2IP_MstRd_d  in  32  shared bus read data
- regif_timeout  out  1  sticky: an owner exceeded HOLD_TIMEOUT
- regif_proto_err  out  1  sticky: drv_regif was raised without an offer

Behaviour:
- Single clock clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - State machine in IDLE.
  - rd_my_regif = wr_my_regif = 0.
  - regif_timeout = regif_proto_err = 0.
  - Offer and hold counters = 0.
  - Shared requests = 0.
- FSM states: IDLE, OFFER_RD, OWN_RD, OFFER_WR, OWN_WR. All my_regif outputs are registered.
- IDLE:
  - One cycle after reset release, goes to OFFER_RD.
- OFFER_X:
  - my_regif_X = 1; the offer counter increments each cycle.
  - If X_drv_regif = 1, go to OWN_X and clear the hold counter.
  - Otherwise, when the counter reaches OFFER_CYCLES-1, go to OFFER_other and clear the counter.
  - If drv is seen in the same cycle the offer expires, ownership wins.
- OWN_X:
  - my_regif_X stays 1; the hold counter increments, saturating.
  - When the hold counter reaches HOLD_TIMEOUT, set regif_timeout. The grant is not revoked.
  - When X_drv_regif falls, drop my_regif_X next cycle and go to OFFER_other (alternation, no starvation).
- Bus mux is combinational from the current state, with zero added latency.
  - Required so a request drop on CmdAck is not extended by a cycle.
  - OWN_RD: IP2Bus_MstRd_Req = rd req, address = rd address, IP2Bus_MstWr_Req = 0.
  - OWN_WR: IP2Bus_MstWr_Req = wr req, address = wr address, write data = wr data, IP2Bus_MstRd_Req = 0.
  - All other states: both requests = 0, address = 0, write data = 0.
- Status gating:
  - The owner receives CmdAck, Cmplt, Error and src_rdy_n unchanged.
  - The non-owner sees 0 on CmdAck, Cmplt and Error, and 1 on src_rdy_n.
  - Read data is broadcast.
- Protocol error: X_drv_regif = 1 while the FSM is not in OFFER_X or OWN_X sets regif_proto_err. The signal is ignored for ownership.
- Both drv asserted while offering X: only X is honoured, and the other raises regif_proto_err.
- Reset mid-transaction: all outputs return to reset values immediately and the bus request drops asynchronously. Engines are reset by the same rst_n.

Decomposition:
- Shared package holds:
  - FSM state encodings (one-hot, 5 bits).
  - Constants for the gated idle status values (status-low = 0, src_rdy_n idle = 1).
- One natural sub-module, regif_arb_mux: the combinational owner mux and status gating, driven by a 2-bit owner vector from the FSM.

Test Plan:
- No activity after reset: rd_my_regif high in cycles 2–5, wr_my_regif high in cycles 6–9, alternating with OFFER_CYCLES=4; shared requests stay 0.
- rd engine raises drv in offer cycle 2, then Req with address 0x0000_0040: shared IP2Bus_MstRd_Req/address follow in the same cycle. CmdAck and Cmplt reach rd only. rd drop of drv yields wr_my_regif=1 the next cycle.
- wr write to address 0x10 with data 0xDEADBEEF while owning: shared MstWr_Req, address and data match the engine's values. Bus2IP_Mst_Error=1 with Cmplt reaches wr only; rd status stays 0 and src_rdy_n=1.
- wr_drv_regif raised during OFFER_RD: regif_proto_err=1, no change to ownership or bus.
- Owner holds drv for 65535 cycles: regif_timeout=1 at that count and stays set; grant is kept until drv falls.
- rst_n asserted during OWN_RD with Req high: shared Req=0 and my_regif=0 immediately; after release the FSM restarts at OFFER_RD.
